// File: rtl/pll_seq_ctrl.sv
// PLL bring-up sequencer: programs divider/VCO/loop-filter registers, verifies them by
// readback, enables the PLL and qualifies lock with bounded retries and a disable-first shutdown.
module pll_seq_ctrl #(
  parameter int LOCK_TIMEOUT = 1024,
  parameter int LOCK_STABLE  = 16,
  parameter int MAX_RETRY    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_div,
  input  logic [3:0] cfg_vco,
  input  logic [5:0] cfg_lpf,
  input  logic       pll_lock,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wen,
  output logic       reg_ren,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       locked,
  output logic       fail,
  output logic [1:0] err_code,
  output logic       lost_lock
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMO_LIM   = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0] STAB_LIM  = SW'(LOCK_STABLE);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_DIV    = 4'd1,
    WR_VCO    = 4'd2,
    WR_LPF    = 4'd3,
    RD_DIV    = 4'd4,
    RD_VCO    = 4'd5,
    RD_LPF    = 4'd6,
    CHK       = 4'd7,
    EN        = 4'd8,
    WAIT_LOCK = 4'd9,
    LOCKED    = 4'd10,
    DIS       = 4'd11,
    FAIL      = 4'd12
  } state_t;

  state_t        state_r, state_s, dis_tgt_r, dis_tgt_s;
  logic          sync1_r, lock_r;
  logic [TW-1:0] tmo_r, tmo_s, tmo_inc_s;
  logic [SW-1:0] stab_r, stab_s, stab_inc_s;
  logic [RW-1:0] retry_r, retry_s;
  logic [1:0]    err_pend_r, err_pend_s, err_code_s;
  logic [7:0]    cap_div_r, cap_div_s;
  logic [3:0]    cap_vco_r, cap_vco_s;
  logic [5:0]    cap_lpf_r, cap_lpf_s;
  logic          capture_s, lost_s;
  logic          wen_s, ren_s;
  logic [7:0]    addr_s, wdata_s;

  // Both counters saturate so a stuck state can never wrap back into a false match.
  assign tmo_inc_s  = (tmo_r == TMO_LIM) ? tmo_r : tmo_r + TW'(1);
  assign stab_inc_s = !lock_r ? {SW{1'b0}} : ((stab_r == STAB_LIM) ? stab_r : stab_r + SW'(1));

  assign cap_div_s = capture_s ? cfg_div : cap_div_r;
  assign cap_vco_s = capture_s ? cfg_vco : cap_vco_r;
  assign cap_lpf_s = capture_s ? cfg_lpf : cap_lpf_r;

  // Next-state logic; abort overrides everything outside IDLE and FAIL.
  always_comb begin
    state_s    = state_r;
    dis_tgt_s  = dis_tgt_r;
    tmo_s      = tmo_r;
    stab_s     = stab_r;
    retry_s    = retry_r;
    err_pend_s = err_pend_r;
    err_code_s = err_code;
    capture_s  = 1'b0;
    lost_s     = 1'b0;
    if (abort && (state_r != IDLE) && (state_r != FAIL)) begin
      state_s   = (state_r == DIS) ? IDLE : DIS;
      dis_tgt_s = IDLE;
    end else begin
      case (state_r)
        IDLE, FAIL: begin
          if (start) begin
            capture_s  = 1'b1;
            retry_s    = {RW{1'b0}};
            err_pend_s = 2'd0;
            err_code_s = 2'd0;
            state_s    = WR_DIV;
          end else begin
            state_s = state_r;
          end
        end
        WR_DIV: state_s = WR_VCO;
        WR_VCO: state_s = WR_LPF;
        WR_LPF: state_s = RD_DIV;
        RD_DIV: state_s = RD_VCO;
        RD_VCO: begin
          if (reg_rdata != cap_div_r) begin
            state_s = DIS; dis_tgt_s = FAIL; err_pend_s = 2'd1;
          end else begin
            state_s = RD_LPF;
          end
        end
        RD_LPF: begin
          if (reg_rdata != {4'b0000, cap_vco_r}) begin
            state_s = DIS; dis_tgt_s = FAIL; err_pend_s = 2'd1;
          end else begin
            state_s = CHK;
          end
        end
        CHK: begin
          if (reg_rdata != {2'b00, cap_lpf_r}) begin
            state_s = DIS; dis_tgt_s = FAIL; err_pend_s = 2'd1;
          end else begin
            state_s = EN;
          end
        end
        EN: begin
          state_s = WAIT_LOCK;
          tmo_s   = {TW{1'b0}};
          stab_s  = {SW{1'b0}};
        end
        WAIT_LOCK: begin
          tmo_s  = tmo_inc_s;
          stab_s = stab_inc_s;
          if (stab_inc_s == STAB_LIM) begin
            state_s = LOCKED;
          end else if (tmo_inc_s == TMO_LIM) begin
            state_s = DIS;
            if (retry_r < RETRY_LIM) begin
              retry_s   = retry_r + RW'(1);
              dis_tgt_s = EN;
            end else begin
              dis_tgt_s  = FAIL;
              err_pend_s = 2'd2;
            end
          end else begin
            state_s = WAIT_LOCK;
          end
        end
        LOCKED: begin
          if (!lock_r) begin
            lost_s  = 1'b1;
            state_s = WAIT_LOCK;
            tmo_s   = {TW{1'b0}};
            stab_s  = {SW{1'b0}};
          end else begin
            state_s = LOCKED;
          end
        end
        DIS: begin
          state_s = dis_tgt_r;
          if (dis_tgt_r == FAIL) begin
            err_code_s = err_pend_r;
          end else begin
            err_code_s = err_code;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Bus decode of the state being entered, so the registered strobes line up with the state.
  always_comb begin
    wen_s   = 1'b0;
    ren_s   = 1'b0;
    addr_s  = 8'h00;
    wdata_s = 8'h00;
    case (state_s)
      WR_DIV: begin wen_s = 1'b1; addr_s = 8'h00; wdata_s = cap_div_s; end
      WR_VCO: begin wen_s = 1'b1; addr_s = 8'h01; wdata_s = {4'b0000, cap_vco_s}; end
      WR_LPF: begin wen_s = 1'b1; addr_s = 8'h02; wdata_s = {2'b00, cap_lpf_s}; end
      RD_DIV: begin ren_s = 1'b1; addr_s = 8'h00; end
      RD_VCO: begin ren_s = 1'b1; addr_s = 8'h01; end
      RD_LPF: begin ren_s = 1'b1; addr_s = 8'h02; end
      EN:     begin wen_s = 1'b1; addr_s = 8'h03; wdata_s = 8'h01; end
      DIS:    begin wen_s = 1'b1; addr_s = 8'h03; wdata_s = 8'h00; end
      default: begin wen_s = 1'b0; ren_s = 1'b0; addr_s = 8'h00; wdata_s = 8'h00; end
    endcase
  end

  // State, counters, lock synchronizer, captured config and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      dis_tgt_r  <= IDLE;
      sync1_r    <= 1'b0;
      lock_r     <= 1'b0;
      tmo_r      <= {TW{1'b0}};
      stab_r     <= {SW{1'b0}};
      retry_r    <= {RW{1'b0}};
      err_pend_r <= 2'd0;
      cap_div_r  <= 8'h00;
      cap_vco_r  <= 4'h0;
      cap_lpf_r  <= 6'h00;
      reg_addr   <= 8'h00;
      reg_wdata  <= 8'h00;
      reg_wen    <= 1'b0;
      reg_ren    <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      err_code   <= 2'd0;
      lost_lock  <= 1'b0;
    end else begin
      state_r    <= state_s;
      dis_tgt_r  <= dis_tgt_s;
      sync1_r    <= pll_lock;
      lock_r     <= sync1_r;
      tmo_r      <= tmo_s;
      stab_r     <= stab_s;
      retry_r    <= retry_s;
      err_pend_r <= err_pend_s;
      cap_div_r  <= cap_div_s;
      cap_vco_r  <= cap_vco_s;
      cap_lpf_r  <= cap_lpf_s;
      reg_addr   <= addr_s;
      reg_wdata  <= wdata_s;
      reg_wen    <= wen_s;
      reg_ren    <= ren_s;
      busy       <= !(state_s inside {IDLE, LOCKED, FAIL});
      locked     <= (state_s == LOCKED);
      fail       <= (state_s == FAIL);
      err_code   <= err_code_s;
      lost_lock  <= lost_s;
    end
  end

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Scoreboard bench for pll_seq_ctrl: expected bus transactions are queued from the sequencing
// rules and a negedge monitor pops and compares each strobe; status outputs are checked inline.
module tb_pll_seq_ctrl;

  localparam int TIMEOUT = 1024;
  localparam int STABLE  = 16;
  localparam int RETRIES = 2;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, pll_lock = 1'b0;
  logic [7:0] cfg_div = 8'h00;
  logic [3:0] cfg_vco = 4'h0;
  logic [5:0] cfg_lpf = 6'h00;
  logic [7:0] reg_rdata = 8'h00;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_wen, reg_ren, busy, locked, fail, lost_lock;
  logic [1:0] err_code;

  pll_seq_ctrl #(.LOCK_TIMEOUT(TIMEOUT), .LOCK_STABLE(STABLE), .MAX_RETRY(RETRIES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_div(cfg_div), .cfg_vco(cfg_vco), .cfg_lpf(cfg_lpf), .pll_lock(pll_lock),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wen(reg_wen), .reg_ren(reg_ren),
    .reg_rdata(reg_rdata), .busy(busy), .locked(locked), .fail(fail),
    .err_code(err_code), .lost_lock(lost_lock));

  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         gap;   // required cycles since previous bus access, -1 = any
  } txn_t;

  txn_t       exp_q[$];
  txn_t       e;
  int         checks = 0, failures = 0;
  int         cyc = 0, last_cyc = 0, lost_cnt = 0;
  logic [7:0] mem [0:3];
  int         corrupt_addr = -1;
  logic [7:0] corrupt_val = 8'h00;

  initial for (int i = 0; i < 4; i++) mem[i] = 8'h00;

  // Register file model: echoes writes, optionally corrupts one readback address.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reg_wen && reg_addr < 8'd4) mem[reg_addr[1:0]] <= reg_wdata;
    if (reg_ren) reg_rdata <= (int'(reg_addr) == corrupt_addr) ? corrupt_val : mem[reg_addr[1:0]];
    else reg_rdata <= 8'h00;
  end

  // Monitor: every bus strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (lost_lock) lost_cnt++;
    if (reg_wen || reg_ren) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL bus_unexpected wen=%0d ren=%0d addr=%0h data=%0h cyc=%0d",
                 reg_wen, reg_ren, reg_addr, reg_wdata, cyc);
      end else begin
        e = exp_q.pop_front();
        if ((reg_wen && reg_ren) || (reg_wen != e.wr) || (reg_ren == e.wr) || (reg_addr != e.addr) ||
            (e.wr && reg_wdata != e.data) || (e.gap >= 0 && (cyc - last_cyc) != e.gap)) begin
          failures++;
          $display("FAIL bus_txn got wen=%0d ren=%0d addr=%0h data=%0h gap=%0d expected wr=%0d addr=%0h data=%0h gap=%0d",
                   reg_wen, reg_ren, reg_addr, reg_wdata, cyc - last_cyc, e.wr, e.addr, e.data, e.gap);
        end
      end
      last_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit wr, input logic [7:0] a, input logic [7:0] d, input int gap);
    txn_t t;
    t.wr = wr; t.addr = a; t.data = d; t.gap = gap;
    exp_q.push_back(t);
  endtask

  // Expected bus traffic from start up to the enable write, or up to the disable on a bad readback.
  task automatic push_seq(input logic [7:0] d, input logic [3:0] v, input logic [5:0] l, input int bad);
    int nreads;
    nreads = (bad < 0) ? 3 : ((bad + 2 > 3) ? 3 : bad + 2);
    push(1'b1, 8'h00, d, -1);
    push(1'b1, 8'h01, {4'b0000, v}, 1);
    push(1'b1, 8'h02, {2'b00, l}, 1);
    for (int i = 0; i < nreads; i++) push(1'b0, 8'(i), 8'h00, 1);
    if (bad < 0) push(1'b1, 8'h03, 8'h01, 2);
    else push(1'b1, 8'h03, 8'h00, (bad == 2) ? 2 : 1);
  endtask

  task automatic start_seq(input logic [7:0] d, input logic [3:0] v, input logic [5:0] l);
    cfg_div = d; cfg_vco = v; cfg_lpf = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_div = 8'($urandom); cfg_vco = 4'($urandom); cfg_lpf = 6'($urandom);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin tick(); n++; end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic lock_rise(input string name);
    int got = 0;
    pll_lock = 1'b1;
    for (int n = 1; n <= 40 && got == 0; n++) begin
      tick();
      if (locked === 1'b1) got = n;
    end
    chk(name, got, 2 + STABLE);
  endtask

  task automatic abort_to_idle(input string name);
    push(1'b1, 8'h03, 8'h00, -1);
    abort = 1'b1;
    tick();
    chk({name, "_dis"}, {reg_wen, reg_ren, reg_addr, reg_wdata}, {1'b1, 1'b0, 8'h03, 8'h00});
    tick();
    chk({name, "_idle"}, {busy, locked, fail, err_code}, 5'b0);
    abort = 1'b0;
    pll_lock = 1'b0;
    tick();
  endtask

  task automatic nominal(input string name, input logic [7:0] d, input logic [3:0] v,
                         input logic [5:0] l, input int delay);
    corrupt_addr = -1;
    push_seq(d, v, l, -1);
    start_seq(d, v, l);
    wait_drain({name, "_drain"}, 50);
    repeat (delay) tick();
    chk({name, "_waiting"}, {busy, locked}, 2'b10);
    lock_rise({name, "_lock_latency"});
    chk({name, "_locked_status"}, {busy, locked, fail, err_code}, 5'b01000);
  endtask

  task automatic readback_err(input string name, input int bad, input logic [7:0] d,
                              input logic [3:0] v, input logic [5:0] l, input logic [7:0] val);
    corrupt_addr = bad;
    corrupt_val = val;
    push_seq(d, v, l, bad);
    start_seq(d, v, l);
    wait_drain({name, "_drain"}, 50);
    tick();
    chk({name, "_status"}, {busy, locked, fail, err_code}, 5'b00101);
    corrupt_addr = -1;
  endtask

  initial begin
    logic [7:0] d, good, mask;
    logic [3:0] v;
    logic [5:0] l;
    int         bad;

    repeat (3) tick();
    chk("reset_outputs", {reg_addr, reg_wdata, reg_wen, reg_ren, busy, locked, fail, err_code, lost_lock}, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    nominal("nominal", 8'h20, 4'h5, 6'b011011, 99);

    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    chk("start_in_locked_ignored", {busy, locked}, 2'b01);

    lost_cnt = 0;
    pll_lock = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      if (n == 3) chk("lost_lock_pulse_timing", {lost_lock, locked}, 2'b10);
    end
    lock_rise("relock_latency");
    chk("lost_lock_count", lost_cnt, 1);
    abort_to_idle("abort_locked");

    for (int r = 0; r < 3; r++) begin
      nominal("rand_nominal", 8'($urandom), 4'($urandom), 6'($urandom), $urandom_range(5, 300));
      abort_to_idle("rand_abort_locked");
    end

    readback_err("rb_err_directed", 0, 8'h20, 4'h5, 6'b011011, 8'h21);
    abort = 1'b1; repeat (3) tick(); abort = 1'b0;
    chk("abort_in_fail_ignored", {fail, err_code}, 3'b101);

    for (int r = 0; r < 3; r++) begin
      d = 8'($urandom); v = 4'($urandom); l = 6'($urandom);
      bad = $urandom_range(0, 2);
      good = (bad == 0) ? d : ((bad == 1) ? {4'b0000, v} : {2'b00, l});
      mask = 8'($urandom_range(1, 255));
      readback_err("rb_err_rand", bad, d, v, l, good ^ mask);
    end

    d = 8'($urandom); v = 4'($urandom); l = 6'($urandom);
    push_seq(d, v, l, -1);
    start_seq(d, v, l);
    wait_drain("abort_wait_drain", 50);
    repeat ($urandom_range(1, 50)) tick();
    chk("abort_wait_status", {busy, locked, fail, err_code}, 5'b10000);
    abort_to_idle("abort_wait_lock");

    d = 8'($urandom); v = 4'($urandom); l = 6'($urandom);
    push_seq(d, v, l, -1);
    for (int r = 0; r <= RETRIES; r++) begin
      push(1'b1, 8'h03, 8'h00, TIMEOUT + 1);
      if (r < RETRIES) push(1'b1, 8'h03, 8'h01, 1);
    end
    start_seq(d, v, l);
    wait_drain("timeout_drain", (RETRIES + 1) * (TIMEOUT + 10) + 50);
    tick();
    chk("timeout_status", {busy, locked, fail, err_code}, 5'b00110);

    d = 8'($urandom); v = 4'($urandom); l = 6'($urandom);
    push(1'b1, 8'h00, d, -1);
    start_seq(d, v, l);
    tick();
    chk("pre_reset_wr_vco", {reg_wen, reg_addr}, {1'b1, 8'h01});
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {reg_addr, reg_wdata, reg_wen, reg_ren, busy, locked, fail, err_code, lost_lock}, 0);
    tick(); tick();
    chk("reset_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("post_reset_idle", {busy, locked, fail, reg_wen, reg_ren}, 5'b0);

    nominal("post_reset_nominal", 8'($urandom), 4'($urandom), 6'($urandom), 20);
    abort_to_idle("final_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog_timeout cycles=%0d limit=60000", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
